// File: rtl/bit_index_encoder_pkg.sv
// Shared constants and state encoding for the bit index encoder.
//   N       : input vector width (fixed at 16)
//   W       : code width, clog2(N)
//   state_t : IDLE (accepting a vector) / EMIT (streaming indices)
package bit_index_encoder_pkg;

    localparam int N = 16;
    localparam int W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_index_encoder_lsb.sv
// Combinational lowest-set-bit encoder.
// Ports:
//   in     [15:0] : vector to encode
//   idx    [3:0]  : index of the lowest set bit (0 when in == 0)
//   any           : at least one bit is set
//   onehot        : exactly one bit is set
module lsb_prio_enc16
    import bit_index_encoder_pkg::*;
(
    input  logic [N-1:0] in,
    output logic [W-1:0] idx,
    output logic         any,
    output logic         onehot
);

    always_comb begin
        idx = '0;
        // Scan from the top down so the lowest set bit is the last to win.
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |in;
    // Clearing the lowest set bit leaves zero only when a single bit was set.
    assign onehot = any && ((in & (in - N'(1))) == '0);

endmodule

// File: rtl/bit_index_encoder.sv
// Bit index encoder: accepts a 16-bit vector and streams the index of every
// set bit, lowest first, one per code handshake.
// Ports:
//   clk, rst_n          : clock (rising edge), async active-low reset
//   d_valid/d_ready/d   : vector input handshake; d_ready is high only in IDLE
//   code_valid/code_ready/code/code_last : index output handshake;
//                         code_last marks the final set bit of the vector
//   err_zero            : one-cycle pulse when an all-zero vector is accepted
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends combinationally on ready, and the payload
// is held stable while valid is high and ready is low.
module bit_index_encoder
    import bit_index_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         d_valid,
    output logic         d_ready,
    input  logic [N-1:0] d,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [W-1:0] code,
    output logic         code_last,
    output logic         err_zero
);

    state_t       state, state_next;
    logic [N-1:0] pend, pend_next;
    logic         err_next;

    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic         enc_onehot;

    lsb_prio_enc16 u_enc (
        .in     (pend),
        .idx    (enc_idx),
        .any    (enc_any),
        .onehot (enc_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= '0;
            err_zero <= 1'b0;
        end else begin
            state    <= state_next;
            pend     <= pend_next;
            err_zero <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        pend_next  = pend;
        err_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (d_valid) begin
                    pend_next = d;
                    if (d != '0) begin
                        state_next = EMIT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (code_ready) begin
                    // pend & (pend - 1) drops exactly the lowest set bit.
                    pend_next = pend & (pend - N'(1));
                    if (enc_onehot) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs come straight from state and pend; pend is zero whenever
    // the block is idle, so code reads 0 outside EMIT.
    assign d_ready    = (state == IDLE);
    assign code_valid = (state == EMIT) && enc_any;
    assign code       = enc_idx;
    assign code_last  = (state == EMIT) && enc_onehot;

endmodule

// File: tb/tb_bit_index_encoder.sv
module tb_bit_index_encoder;

    logic        clk;
    logic        rst_n;
    logic        d_valid;
    logic        d_ready;
    logic [15:0] d;
    logic        code_valid;
    logic        code_ready;
    logic [3:0]  code;
    logic        code_last;
    logic        err_zero;

    int tests = 0;
    int fails = 0;

    // Expected {code_last, code} per handshake, and vectors for round-trip checks.
    logic [4:0]  exp_q[$];
    logic [15:0] vec_q[$];
    int          err_exp  = 0;
    int          err_seen = 0;
    bit          rdy_rand = 0;

    bit          stall_hold = 0;
    logic [4:0]  held;
    logic [15:0] acc = '0;

    bit_index_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d          (d),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .code_last  (code_last),
        .err_zero   (err_zero)
    );

    // ---------------- clock / reset ----------------
    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: list every set bit from index 0 upward.
    task automatic model_push(input logic [15:0] v);
        int cnt = 0;
        int seen = 0;
        for (int i = 0; i < 16; i++) if (v[i]) cnt++;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                seen++;
                exp_q.push_back({(seen == cnt) ? 1'b1 : 1'b0, 4'(i)});
            end
        end
        if (cnt > 0) vec_q.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] v);
        int n = 0;
        while (!d_ready && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (!d_ready) begin
            check("d_ready_timeout", 0, 1);
        end else begin
            d_valid = 1;
            d = v;
            if (v == 0) err_exp++;
            else model_push(v);
            @(posedge clk); #1;
            d_valid = 0;
            d = $urandom;
            if (v == 0) begin
                check("zero_err_pulse", err_zero, 1);
                check("zero_no_valid", code_valid, 0);
                check("zero_ready", d_ready, 1);
                @(posedge clk); #1;
                check("zero_err_one_clk", err_zero, 0);
            end else begin
                check("accept_latency", code_valid, 1);
                check("busy_not_ready", d_ready, 0);
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !d_ready) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("drain_timeout", (exp_q.size() == 0 && d_ready) ? 1 : 0, 1);
    endtask

    // Random ready generator when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rdy_rand) code_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_hold = 0;
            acc = '0;
        end else begin
            if (err_zero) err_seen++;
            if (code_valid) begin
                if (stall_hold) check("stall_stable", {code_last, code}, held);
                if (code_ready) begin
                    stall_hold = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_code", {code_last, code}, 5'h1f);
                    end else begin
                        check("code", {code_last, code}, exp_q.pop_front());
                        acc = acc | (16'(1) << code);
                        if (code_last) begin
                            if (vec_q.size() != 0) check("round_trip", acc, vec_q.pop_front());
                            acc = '0;
                        end
                    end
                end else begin
                    stall_hold = 1;
                    held = {code_last, code};
                end
            end else begin
                stall_hold = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 0; d_valid = 0; d = '0; code_ready = 0;
        #12;
        check("rst_code_valid", code_valid, 0);
        check("rst_code", code, 0);
        check("rst_err", err_zero, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("rst_d_ready", d_ready, 1);

        // single bit
        code_ready = 1;
        send(16'h0020);
        @(posedge clk); #1;
        check("single_back_idle", d_ready, 1);

        // three bits on consecutive clocks
        send(16'h8101);
        repeat (3) @(posedge clk);
        #1;
        check("burst_back_idle", d_ready, 1);

        // stall
        code_ready = 0;
        send(16'h0006);
        repeat (3) @(posedge clk);
        #1;
        check("stall_code", code, 1);
        check("stall_valid", code_valid, 1);
        code_ready = 1;
        wait_idle();

        // zero vector
        send(16'h0000);

        // round-trip for all one-hot vectors
        for (int i = 0; i < 16; i++) send(16'(1) << i);
        wait_idle();

        // random vectors with random backpressure
        rdy_rand = 1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) send(16'h0000);
            else send(16'($urandom));
        end
        wait_idle();

        // reset mid-EMIT
        rdy_rand = 0;
        code_ready = 0;
        send(16'hffff);
        @(posedge clk); #1;
        rst_n = 0;
        exp_q.delete();
        vec_q.delete();
        #1;
        check("midrst_code_valid", code_valid, 0);
        check("midrst_code", code, 0);
        check("midrst_last", code_last, 0);
        check("midrst_err", err_zero, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        check("midrst_d_ready", d_ready, 1);
        check("midrst_no_valid", code_valid, 0);

        code_ready = 1;
        send(16'h0300);
        wait_idle();

        check("err_pulse_count", err_seen, err_exp);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
